// File: rtl/texel_line_cache.sv
// Direct-mapped read cache for 64-bit VRAM texel words.
// One outstanding request; misses issue a single VRAM read.
module texel_line_cache #(
    parameter int LINES  = 16,
    parameter int ADDR_W = 21,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_word_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [63:0]       resp_data,
    input  logic              resp_ready,
    input  logic              flush,
    output logic              vram_rd,
    output logic [ADDR_W-1:0] vram_word_addr,
    input  logic              vram_wait,
    input  logic              vram_valid,
    input  logic [63:0]       vram_din,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LINES-1:0]  line_valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [63:0]       data_mem [LINES];
    logic              issued;
    logic              fill_flushed;

    logic [IDX_W-1:0]  idx_q;
    logic [TAG_W-1:0]  tag_q;
    logic              lookup_hit;
    logic              fill_we;

    assign idx_q      = addr_q[IDX_W-1:0];
    assign tag_q      = addr_q[ADDR_W-1:IDX_W];
    assign lookup_hit = line_valid[idx_q] && (tag_mem[idx_q] == tag_q) && !flush;
    assign req_ready  = (state == IDLE) && !flush && !reset;
    assign fill_we    = (state == FILL) && issued && vram_valid;

    // Tag and data arrays carry no reset; validity lives in line_valid only.
    always_ff @(posedge clock) begin
        if (!reset && fill_we) begin
            tag_mem[idx_q]  <= tag_q;
            data_mem[idx_q] <= vram_din;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            addr_q         <= '0;
            line_valid     <= '0;
            resp_valid     <= 1'b0;
            resp_data      <= '0;
            vram_rd        <= 1'b0;
            vram_word_addr <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
            issued         <= 1'b0;
            fill_flushed   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q <= req_word_addr;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lookup_hit) begin
                        resp_data  <= data_mem[idx_q];
                        resp_valid <= 1'b1;
                        if (hit_count != '1) hit_count <= hit_count + 1'b1;
                        state      <= RESP;
                    end else begin
                        if (miss_count != '1) miss_count <= miss_count + 1'b1;
                        vram_rd        <= 1'b1;
                        vram_word_addr <= addr_q;
                        issued         <= 1'b0;
                        fill_flushed   <= 1'b0;
                        state          <= FILL;
                    end
                end
                FILL: begin
                    if (flush) fill_flushed <= 1'b1;
                    if (!issued) begin
                        if (!vram_wait) begin
                            vram_rd <= 1'b0;
                            issued  <= 1'b1;
                        end
                    end else if (vram_valid) begin
                        // A flush seen at any point of the fill leaves the line invalid.
                        if (!flush && !fill_flushed) line_valid[idx_q] <= 1'b1;
                        resp_data  <= vram_din;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (flush) line_valid <= '0;
        end
    end
endmodule

// File: tb/tb_texel_line_cache.sv
// Directed and randomized bench for texel_line_cache against an array-based cache model.
module tb_texel_line_cache;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic [20:0] req_word_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_ready = 1'b0;
    logic        flush = 1'b0;
    logic        vram_rd;
    logic [20:0] vram_word_addr;
    logic        vram_wait = 1'b0;
    logic        vram_valid = 1'b0;
    logic [63:0] vram_din = '0;
    logic [3:0]  hit_count;
    logic [3:0]  miss_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: per-line valid/tag/data plus saturating counters.
    bit          mv [16];
    logic [16:0] mt [16];
    logic [63:0] md [16];
    int          hits   = 0;
    int          misses = 0;

    texel_line_cache #(.LINES(16), .ADDR_W(21), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_word_addr(req_word_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
        .flush(flush),
        .vram_rd(vram_rd), .vram_word_addr(vram_word_addr), .vram_wait(vram_wait),
        .vram_valid(vram_valid), .vram_din(vram_din),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    endtask

    // fmode: 0 none, 1 flush during LOOKUP, 2 flush during FILL
    task automatic txn(input logic [20:0] a, input logic [63:0] vd, input int wt,
                       input int lat, input int rstall, input int fmode);
        logic [3:0]  idx;
        logic [16:0] tg;
        bit          exp_hit;
        logic [63:0] exp_data;
        idx = a[3:0];
        tg  = a[20:4];
        req_word_addr = a;
        req_valid     = 1'b1;
        check("req_ready", {63'd0, req_ready}, 64'd1);
        step();
        req_valid     = 1'b0;
        req_word_addr = 21'($urandom);
        check("lookup_resp_valid", {63'd0, resp_valid}, 64'd0);
        vram_valid = 1'b1;
        vram_din   = {$urandom, $urandom};
        if (fmode == 1) begin
            flush = 1'b1;
            model_clear();
        end
        exp_hit = mv[idx] && (mt[idx] == tg);
        step();
        flush      = 1'b0;
        vram_valid = 1'b0;
        if (exp_hit) begin
            check("hit_vram_rd", {63'd0, vram_rd}, 64'd0);
            exp_data = md[idx];
            if (hits < 15) hits++;
        end else begin
            if (misses < 15) misses++;
            check("fill_vram_rd", {63'd0, vram_rd}, 64'd1);
            check("fill_addr", {43'd0, vram_word_addr}, {43'd0, a});
            check("fill_resp_valid", {63'd0, resp_valid}, 64'd0);
            vram_wait = (wt > 0);
            for (int i = 0; i < wt; i++) begin
                vram_valid = 1'b1;
                vram_din   = {$urandom, $urandom};
                step();
                check("wait_vram_rd", {63'd0, vram_rd}, 64'd1);
                check("wait_addr", {43'd0, vram_word_addr}, {43'd0, a});
            end
            vram_wait  = 1'b0;
            vram_valid = 1'b0;
            if (fmode == 2) flush = 1'b1;
            step();
            flush = 1'b0;
            check("issued_vram_rd", {63'd0, vram_rd}, 64'd0);
            for (int i = 0; i < lat; i++) begin
                step();
                check("lat_resp_valid", {63'd0, resp_valid}, 64'd0);
                check("lat_vram_rd", {63'd0, vram_rd}, 64'd0);
            end
            vram_valid = 1'b1;
            vram_din   = vd;
            step();
            vram_valid = 1'b0;
            vram_din   = {$urandom, $urandom};
            exp_data   = vd;
            if (fmode == 2) model_clear();
            else begin
                mv[idx] = 1'b1;
                mt[idx] = tg;
                md[idx] = vd;
            end
        end
        check("resp_valid", {63'd0, resp_valid}, 64'd1);
        check("resp_data", resp_data, exp_data);
        for (int i = 0; i < rstall; i++) begin
            step();
            check("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
            check("stall_resp_data", resp_data, exp_data);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("done_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("done_req_ready", {63'd0, req_ready}, 64'd1);
        check("hit_count", {60'd0, hit_count}, 64'(hits));
        check("miss_count", {60'd0, miss_count}, 64'(misses));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {63'd0, req_ready}, 64'd0);
        check({tag, "_resp_valid"}, {63'd0, resp_valid}, 64'd0);
        check({tag, "_resp_data"}, resp_data, 64'd0);
        check({tag, "_vram_rd"}, {63'd0, vram_rd}, 64'd0);
        check({tag, "_vram_addr"}, {43'd0, vram_word_addr}, 64'd0);
        check({tag, "_hits"}, {60'd0, hit_count}, 64'd0);
        check({tag, "_misses"}, {60'd0, miss_count}, 64'd0);
    endtask

    initial begin
        logic [16:0] rt;
        logic [3:0]  ri;
        model_clear();
        repeat (3) step();
        check_reset_outputs("reset");
        reset = 1'b0;
        #1;
        check("req_ready_after_reset", {63'd0, req_ready}, 64'd1);
        step();

        // Cold miss, then hit
        txn(21'h000123, 64'hDEADBEEF_01234567, 0, 5, 0, 0);
        txn(21'h000123, 64'h0, 0, 0, 0, 0);
        // Conflict on index 3; neighbouring index 4 untouched
        txn(21'h000124, 64'h4444_0000_1111_2222, 0, 1, 0, 0);
        txn(21'h000133, 64'h1330_1330_1330_1330, 0, 2, 0, 0);
        txn(21'h000123, 64'h1230_1230_1230_1230, 0, 0, 1, 0);
        txn(21'h000124, 64'h0, 0, 0, 0, 0);
        // Backpressure on both sides
        txn(21'h000200, 64'hCAFE_F00D_1234_5678, 4, 1, 3, 0);
        // Flush during FILL, then same address misses again
        txn(21'h000300, 64'h3000_0000_0000_0003, 1, 2, 0, 2);
        txn(21'h000300, 64'h3000_0000_0000_0004, 0, 0, 0, 0);
        // Flush during LOOKUP forces a miss on a resident line
        txn(21'h000300, 64'h3000_0000_0000_0005, 0, 0, 0, 1);

        for (int n = 0; n < 40; n++) begin
            rt = 17'($urandom_range(0, 3));
            ri = 4'($urandom_range(0, 3));
            txn({rt, ri}, {$urandom, $urandom}, $urandom_range(0, 2),
                $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0);
        end

        // Saturation of hit counter
        txn(21'h000777, 64'h7777_7777_7777_7777, 0, 0, 0, 0);
        for (int n = 0; n < 20; n++) txn(21'h000777, 64'h0, 0, 0, 0, 0);
        check("hit_count_saturated", {60'd0, hit_count}, 64'd15);

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        #1;
        check("flush_req_ready", {63'd0, req_ready}, 64'd0);
        step();
        flush = 1'b0;
        model_clear();

        // Reset mid-FILL
        req_word_addr = 21'h000555;
        req_valid     = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("rst_fill_vram_rd", {63'd0, vram_rd}, 64'd1);
        vram_wait = 1'b1;
        step();
        reset = 1'b1;
        step();
        check_reset_outputs("midfill");
        reset     = 1'b0;
        vram_wait = 1'b0;
        hits      = 0;
        misses    = 0;
        model_clear();
        #1;
        check("midfill_req_ready", {63'd0, req_ready}, 64'd1);
        vram_valid = 1'b1;
        vram_din   = 64'hBAD0_BAD0_BAD0_BAD0;
        repeat (3) begin
            step();
            check("stray_resp_valid", {63'd0, resp_valid}, 64'd0);
            check("stray_vram_rd", {63'd0, vram_rd}, 64'd0);
        end
        vram_valid = 1'b0;
        txn(21'h000555, 64'h5555_AAAA_5555_AAAA, 0, 1, 0, 0);
        txn(21'h000555, 64'h0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
